// File: rtl/decode_pkg.sv
// Shared types and encodings for the instruction-decode stage.
// Opcode/funct values, ALU function selects, occupancy state and the
// decoded-word struct carried through the two-entry skid buffer.
package decode_pkg;

    // I-type opcodes (ibus[IW-1:IW-6])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_XORI  = 6'b000001;
    localparam logic [5:0] OP_SUBI  = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b000011;
    localparam logic [5:0] OP_ORI   = 6'b001100;
    localparam logic [5:0] OP_ANDI  = 6'b001111;

    // R-type funct codes (ibus[5:0], valid only with OP_RTYPE)
    localparam logic [5:0] FN_XOR = 6'b000001;
    localparam logic [5:0] FN_SUB = 6'b000010;
    localparam logic [5:0] FN_ADD = 6'b000011;
    localparam logic [5:0] FN_OR  = 6'b000100;
    localparam logic [5:0] FN_AND = 6'b000111;

    // ALU function select encodings
    localparam logic [2:0] SID_XOR = 3'b000;
    localparam logic [2:0] SID_ADD = 3'b010;
    localparam logic [2:0] SID_SUB = 3'b011;
    localparam logic [2:0] SID_OR  = 3'b100;
    localparam logic [2:0] SID_AND = 3'b110;

    // Skid-buffer occupancy
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_state_e;

    // Decoded word. imm_ext holds the raw 16-bit immediate; the stage
    // sign-extends it to DW at the output port so the stored entries do
    // not depend on the datapath width.
    typedef struct packed {
        logic        ill;
        logic        imm;
        logic [2:0]  sid;
        logic        cin;
        logic [15:0] imm_ext;
    } dec_word_t;

endpackage

// File: rtl/decode_stage_lut.sv
// opcode_decode_lut: purely combinational instruction-word to decoded-word
// lookup. Unknown opcodes, and R-type words with an unknown funct, come
// out as ILL with a neutral XOR/no-carry/register-operand encoding.
module opcode_decode_lut
    import decode_pkg::*;
#(
    parameter int IW = 32
) (
    input  logic [IW-1:0] ibus,
    output dec_word_t     dec
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_ibus_bits;

    assign opcode = ibus[IW-1:IW-6];
    assign funct  = ibus[5:0];

    // Register-number fields are not used by this stage.
    assign unused_ibus_bits = ^ibus[IW-7:16];

    // Decode opcode, and funct for R-type words
    always_comb begin
        dec         = '0;
        dec.imm_ext = ibus[15:0];
        case (opcode)
            OP_ADDI: begin dec.sid = SID_ADD; dec.imm = 1'b1; end
            OP_SUBI: begin dec.sid = SID_SUB; dec.cin = 1'b1; dec.imm = 1'b1; end
            OP_XORI: begin dec.sid = SID_XOR; dec.imm = 1'b1; end
            OP_ANDI: begin dec.sid = SID_AND; dec.imm = 1'b1; end
            OP_ORI:  begin dec.sid = SID_OR;  dec.imm = 1'b1; end
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  dec.sid = SID_ADD;
                    FN_SUB:  begin dec.sid = SID_SUB; dec.cin = 1'b1; end
                    FN_XOR:  dec.sid = SID_XOR;
                    FN_AND:  dec.sid = SID_AND;
                    FN_OR:   dec.sid = SID_OR;
                    default: dec.ill = 1'b1;
                endcase
            end
            default: dec.ill = 1'b1;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered decode stage with a two-entry skid buffer.
// Words are decoded at the input, so both the output register and the
// skid entry hold decoded words. in_ready is a flop, so out_ready never
// reaches in_ready combinationally.
// Optional feature: define DECODE_ILL_CNT_EN to add the saturating
// illegal-instruction counter and its ill_count port.
module decode_stage
    import decode_pkg::*;
#(
    parameter int IW = 32,
    parameter int DW = 32
`ifdef DECODE_ILL_CNT_EN
    ,
    parameter int CNT_W = 8
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] ibus,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          ImmID,
    output logic [2:0]    SID,
    output logic          CinID,
    output logic          ILL,
    output logic [DW-1:0] imm_ext
`ifdef DECODE_ILL_CNT_EN
    ,
    output logic [CNT_W-1:0] ill_count
`endif
);

    dec_word_t  dec_in;
    dec_word_t  out_q, out_d;
    dec_word_t  skid_q, skid_d;
    occ_state_e state_q, state_d;
    logic       in_ready_q;
    logic       accept;
    logic       pop;

    opcode_decode_lut #(.IW(IW)) u_lut (
        .ibus (ibus),
        .dec  (dec_in)
    );

    assign accept    = in_valid & in_ready_q;
    assign out_valid = (state_q != OCC_EMPTY);
    assign pop       = out_valid & out_ready;
    assign in_ready  = in_ready_q;

    // Occupancy next-state and entry loads; flush wins over pop and accept
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = OCC_EMPTY;
        end else begin
            case (state_q)
                OCC_EMPTY: begin
                    if (accept) begin
                        state_d = OCC_ONE;
                        out_d   = dec_in;
                    end
                end
                OCC_ONE: begin
                    if (accept && pop) begin
                        out_d = dec_in;
                    end else if (accept) begin
                        state_d = OCC_TWO;
                        skid_d  = dec_in;
                    end else if (pop) begin
                        state_d = OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    if (pop) begin
                        state_d = OCC_ONE;
                        out_d   = skid_q;
                    end
                end
                default: state_d = OCC_EMPTY;
            endcase
        end
    end

    // State, entries and the registered ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= OCC_EMPTY;
            in_ready_q <= 1'b1;
            out_q      <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != OCC_TWO);
            out_q      <= out_d;
            skid_q     <= skid_d;
        end
    end

    assign ImmID = out_q.imm;
    assign SID   = out_q.sid;
    assign CinID = out_q.cin;
    assign ILL   = out_q.ill;

    generate
        if (DW > 16) begin : g_sext
            assign imm_ext = {{(DW-16){out_q.imm_ext[15]}}, out_q.imm_ext};
        end else begin : g_noext
            assign imm_ext = out_q.imm_ext;
        end
    endgenerate

`ifdef DECODE_ILL_CNT_EN
    logic [CNT_W-1:0] ill_cnt_q;

    // Saturating count of illegal words taken over the handshake; a flush
    // does not undo the handshake, so it neither clears nor skips a count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ill_cnt_q <= '0;
        end else if (accept && dec_in.ill && (ill_cnt_q != '1)) begin
            ill_cnt_q <= ill_cnt_q + CNT_W'(1);
        end
    end

    assign ill_count = ill_cnt_q;
`endif

endmodule
